// File: rtl/gf_mult_seq.sv
// ---------------------------------------------------------------------------
// gf_mult_seq
//   Sequential GF(2^WIDTH) multiplier for two arbitrary field elements.
//   The multiplier operand B is scanned MSB first. Each RUN cycle retires
//   DIGIT bits of B with Horner steps, so a product takes WIDTH/DIGIT cycles.
//   Both sides use a valid/ready handshake. A finished product is held in
//   DONE until the consumer takes it. A new pair may be accepted on the
//   same edge that the result is handed off.
//
// Parameters
//   WIDTH  field degree m; operands and result are WIDTH bits
//   POLY   reduction polynomial without the implicit x^WIDTH term
//   DIGIT  B bits consumed per RUN cycle; must divide WIDTH
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair in_a/in_b valid
//   in_ready   out  1      block can accept an operand pair
//   in_a       in   WIDTH  multiplicand
//   in_b       in   WIDTH  multiplier (scanned MSB first)
//   out_valid  out  1      out_data holds a finished product
//   out_ready  in   1      consumer accepts out_data
//   out_data   out  WIDTH  product in_a*in_b mod (x^WIDTH + POLY)
//   busy       out  1      high while a product is being computed
// ---------------------------------------------------------------------------
module gf_mult_seq #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h1B,
    parameter int               DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int             STEPS = WIDTH / DIGIT;
    localparam int             CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0]  LAST  = CW'(STEPS - 1);

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("gf_mult_seq: DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    count_q;

    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] b_n;
    logic             accept;

    // Multiply by x, then reduce if the shifted-out bit was set.
    function automatic logic [WIDTH-1:0] xt(input logic [WIDTH-1:0] v);
        return (v << 1) ^ (v[WIDTH-1] ? POLY : '0);
    endfunction

    // The result can be handed off and a new pair taken on the same edge.
    // So in_ready depends on out_ready. It never depends on in_valid.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // This block runs DIGIT Horner steps for the next RUN edge.
    always_comb begin
        // NOTE: every variable gets a default before the loop. Otherwise a
        // path that skips an assignment would infer a latch.
        acc_n = acc_q;
        b_n   = b_q;
        for (int i = 0; i < DIGIT; i++) begin
            acc_n = xt(acc_n) ^ (b_n[WIDTH-1] ? a_q : '0);
            b_n   = b_n << 1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from the values it had before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else if (accept) begin
            // This covers a fresh start from IDLE and a back-to-back load
            // from DONE.
            a_q       <= in_a;
            b_q       <= in_b;
            acc_q     <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
        end else begin
            case (state)
                RUN: begin
                    acc_q   <= acc_n;
                    b_q     <= b_n;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        out_data  <= acc_n;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_gf_mult_seq
//   Self-checking bench for gf_mult_seq.
//   The main instance uses the default AES parameters. It is driven by
//   directed vectors and a random phase. Expected products are queued when
//   a pair is accepted. A negedge monitor pops the queue on every output
//   handshake and compares. Two extra instances cover DIGIT=2 and WIDTH=4.
// ---------------------------------------------------------------------------
module tb_gf_mult_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    // Main instance: WIDTH=8, POLY=0x1B, DIGIT=1
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    gf_mult_seq u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Instance with two B bits per cycle
    logic       iv1 = 1'b0;
    logic       ir1;
    logic [7:0] a1 = '0;
    logic [7:0] b1 = '0;
    logic       ov1;
    logic       or1 = 1'b1;
    logic [7:0] d1;
    logic       bz1;

    gf_mult_seq #(.WIDTH(8), .POLY(8'h1B), .DIGIT(2)) u_dig2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .in_a      (a1),
        .in_b      (b1),
        .out_valid (ov1),
        .out_ready (or1),
        .out_data  (d1),
        .busy      (bz1)
    );

    // GF(2^4) instance with x^4+x+1
    logic       iv2 = 1'b0;
    logic       ir2;
    logic [3:0] a2 = '0;
    logic [3:0] b2 = '0;
    logic       ov2;
    logic       or2 = 1'b1;
    logic [3:0] d2;
    logic       bz2;

    gf_mult_seq #(.WIDTH(4), .POLY(4'h3), .DIGIT(1)) u_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .in_a      (a2),
        .in_b      (b2),
        .out_valid (ov2),
        .out_ready (or2),
        .out_data  (d2),
        .busy      (bz2)
    );

    int         checks   = 0;
    int         errors   = 0;
    int         n_issued = 0;
    int         n_recv   = 0;
    logic [7:0] exp_q[$];
    logic       rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: LSB-first shift-and-add over GF(2^8)/0x11B
    function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Scoreboard monitor: the handshake completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none at %0t", out_data, $time);
            end else begin
                n_recv++;
                check("product", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Random consumer backpressure during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Offer a pair, push its expected product on acceptance, and then
    // measure the clocks from the accepting edge until out_valid rises.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e,
                        output int lat);
        int w = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            w++;
        end while (!in_ready && w < 200);
        check("accept_timeout", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(e);
        n_issued++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 8'($urandom);   // late operand changes must not matter
        in_b     = 8'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 50);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    int lat;

    initial begin
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 0x57*0x83 = 0xC1. The consumer is stalled, so the result waits.
        send(8'h57, 8'h83, 8'hC1, lat);
        check("lat_c1", lat, 32'd8);
        for (int i = 0; i < 5; i++) begin
            check("bp_data", {24'd0, out_data}, 32'hC1);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
        end
        // Hand off 0xC1 and load 0x02*0x87 on the same edge.
        in_a      = 8'h02;
        in_b      = 8'h87;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(8'h15);
        n_issued++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_out_valid", {31'd0, out_valid}, 32'd0);
        check("b2b_run_in_ready", {31'd0, in_ready}, 32'd0);
        drain();

        // Reset during RUN: the operation is dropped and no output appears.
        in_a     = 8'h57;
        in_b     = 8'h83;
        in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("mid_no_output", {31'd0, out_valid}, 32'd0);
        send(8'h57, 8'h83, 8'hC1, lat);
        check("lat_after_rst", lat, 32'd8);

        // Directed vectors, including the zero operand at full latency
        send(8'h57, 8'h13, 8'hFE, lat);
        check("lat_fe", lat, 32'd8);
        send(8'hA5, 8'h01, 8'hA5, lat);
        check("lat_a5", lat, 32'd8);
        send(8'h00, 8'hFF, 8'h00, lat);
        check("lat_zero", lat, 32'd8);
        drain();

        // DIGIT=2: 0x57*0x83 = 0xC1 in 4 clocks
        iv1 = 1'b1;
        a1  = 8'h57;
        b1  = 8'h83;
        @(negedge clk);
        check("d2_in_ready", {31'd0, ir1}, 32'd1);
        @(posedge clk);
        #1 iv1 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov1 && lat < 50);
        check("d2_lat", lat, 32'd4);
        check("d2_data", {24'd0, d1}, 32'hC1);

        // GF(2^4)/x^4+x+1: 0x7*0xB = 0x4
        iv2 = 1'b1;
        a2  = 4'h7;
        b2  = 4'hB;
        @(negedge clk);
        check("w4_in_ready", {31'd0, ir2}, 32'd1);
        @(posedge clk);
        #1 iv2 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov2 && lat < 50);
        check("w4_lat", lat, 32'd4);
        check("w4_data", {28'd0, d2}, 32'h4);

        // Random pairs with random idle gaps and consumer stalls
        rand_rdy = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clk);
                #1;
            end
            send(ra, rb, gf_ref(ra, rb), lat);
            check("lat_rand", lat, 32'd8);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        check("recv_count", n_recv, n_issued);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
